// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Bundles the client ports (CPU rd/wr, video rd) and the single-op
//   controller command interface used by sdram_port_arbiter.
//   modport master : arbiter view (drives acks/read data to clients and
//                    command pulses/addr/data to the controller)
//   modport slave  : environment view (clients and memory controller)
//   Signals:
//     cpu_req/cpu_we/cpu_addr[21:0]/cpu_din[15:0]/cpu_wdm[1:0] -> arbiter
//     cpu_ack, cpu_dout[15:0]                                  <- arbiter
//     vid_req/vid_addr[21:0]                                   -> arbiter
//     vid_ack, vid_dout[15:0]                                  <- arbiter
//     mc_read/mc_write/mc_refresh, mc_addr/mc_din/mc_wdm       <- arbiter
//     mc_dout[15:0], mc_busy                                   -> arbiter
interface sdram_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_wdm;
  logic        cpu_ack;
  logic [15:0] cpu_dout;

  logic        vid_req;
  logic [21:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_dout;

  logic        mc_read;
  logic        mc_write;
  logic        mc_refresh;
  logic [21:0] mc_addr;
  logic [15:0] mc_din;
  logic [1:0]  mc_wdm;
  logic [15:0] mc_dout;
  logic        mc_busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wdm,
    output cpu_ack, cpu_dout,
    input  vid_req, vid_addr,
    output vid_ack, vid_dout,
    output mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
    input  mc_dout, mc_busy
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wdm,
    input  cpu_ack, cpu_dout,
    output vid_req, vid_addr,
    input  vid_ack, vid_dout,
    input  mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
    output mc_dout, mc_busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Upstream stage of the SDRAM controller. Arbitrates a CPU port (rd/wr),
//   a video-fetch port (rd) and an internal periodic refresh timer onto the
//   controller's single-op read/write/refresh pulse interface, tracks the
//   controller busy flag and returns read data with a one-cycle ack.
// Ports
//   clk     : main clock
//   resetn  : asynchronous, active-low reset
//   bus     : sdram_port_arbiter_if.master (client + controller signals)
//   arb_err : sticky watchdog error (tied 0 without ARB_WDOG_EN)
// Parameters
//   FREQ (Hz), REFRESH_NS (refresh interval), WDOG_CYCLES (WAIT timeout)
// Build option
//   ARB_WDOG_EN : enables the WAIT-state watchdog and arb_err.
module sdram_port_arbiter #(
  parameter int unsigned FREQ        = 54_000_000,
  parameter int unsigned REFRESH_NS  = 7800,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  sdram_port_arbiter_if.master        bus,
  output logic                        arb_err
);

  localparam int unsigned REFRESH_CYCLES = (FREQ / 1_000_000) * REFRESH_NS / 1000;
  localparam int unsigned RCW            = $clog2(REFRESH_CYCLES);
  localparam logic [RCW-1:0] REF_LAST    = RCW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_CPU, OWN_VID, OWN_REF} owner_e;
  typedef enum logic {CL_CPU, CL_VID} client_e;

  state_e      state_q,    state_d;
  owner_e      owner_q,    owner_d;
  logic        own_we_q,   own_we_d;
  client_e     rr_last_q,  rr_last_d;
  logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]  ref_pend_q, ref_pend_d;

  logic        mc_read_q,    mc_read_d;
  logic        mc_write_q,   mc_write_d;
  logic        mc_refresh_q, mc_refresh_d;
  logic [21:0] mc_addr_q,    mc_addr_d;
  logic [15:0] mc_din_q,     mc_din_d;
  logic [1:0]  mc_wdm_q,     mc_wdm_d;

  logic        cpu_ack_q,  cpu_ack_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic        vid_ack_q,  vid_ack_d;
  logic [15:0] vid_dout_q, vid_dout_d;

  logic        ref_tick;
  logic        grant_ref;
  logic        cpu_pend;
  logic        vid_pend;
  logic        done;
  logic [15:0] done_data;

`ifdef ARB_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           arb_err_q,  arb_err_d;
`endif

  // Refresh timer only runs once the controller has finished init.
  assign ref_tick = (state_q != S_INIT) && (ref_cnt_q == REF_LAST);

  // A client acked this cycle still shows its stale req; ignore it once.
  assign cpu_pend = bus.cpu_req & ~cpu_ack_q;
  assign vid_pend = bus.vid_req & ~vid_ack_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    own_we_d     = own_we_q;
    rr_last_d    = rr_last_q;
    ref_cnt_d    = ref_cnt_q;
    ref_pend_d   = ref_pend_q;
    mc_read_d    = 1'b0;
    mc_write_d   = 1'b0;
    mc_refresh_d = 1'b0;
    mc_addr_d    = mc_addr_q;
    mc_din_d     = mc_din_q;
    mc_wdm_d     = mc_wdm_q;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    cpu_dout_d   = cpu_dout_q;
    vid_dout_d   = vid_dout_q;
    grant_ref    = 1'b0;
    done         = 1'b0;
    done_data    = bus.mc_dout;
`ifdef ARB_WDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    arb_err_d    = arb_err_q;
`endif

    if (state_q != S_INIT) begin
      ref_cnt_d = ref_tick ? '0 : ref_cnt_q + 1'b1;
    end

    case (state_q)
      S_INIT: begin
        if (!bus.mc_busy) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (ref_pend_q >= 2'd2) begin
          grant_ref = 1'b1;
        end else if (cpu_pend || vid_pend) begin
          // Tie goes to whichever client did not win last.
          if (vid_pend && (!cpu_pend || rr_last_q == CL_CPU)) begin
            owner_d   = OWN_VID;
            own_we_d  = 1'b0;
            rr_last_d = CL_VID;
            mc_read_d = 1'b1;
            mc_addr_d = bus.vid_addr;
          end else begin
            owner_d   = OWN_CPU;
            own_we_d  = bus.cpu_we;
            rr_last_d = CL_CPU;
            mc_addr_d = bus.cpu_addr;
            if (bus.cpu_we) begin
              mc_write_d = 1'b1;
              mc_din_d   = bus.cpu_din;
              mc_wdm_d   = bus.cpu_wdm;
            end else begin
              mc_read_d  = 1'b1;
            end
          end
          state_d = S_ISSUE;
        end else if (ref_pend_q != 2'd0) begin
          grant_ref = 1'b1;
        end

        if (grant_ref) begin
          owner_d      = OWN_REF;
          own_we_d     = 1'b0;
          mc_refresh_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ARB_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        if (!bus.mc_busy) begin
          done = 1'b1;
        end
`ifdef ARB_WDOG_EN
        else if (wdog_cnt_q == WDW'(WDOG_CYCLES - 1)) begin
          done      = 1'b1;
          done_data = 16'hDEAD;
          arb_err_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = S_INIT;
    endcase

    if (done) begin
      state_d = S_IDLE;
      case (owner_q)
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (!own_we_q) cpu_dout_d = done_data;
        end
        OWN_VID: begin
          vid_ack_d  = 1'b1;
          vid_dout_d = done_data;
        end
        default: ;
      endcase
    end

    // A tick coinciding with a refresh grant leaves the backlog unchanged.
    case ({ref_tick, grant_ref})
      2'b10:   if (ref_pend_q != 2'd3) ref_pend_d = ref_pend_q + 2'd1;
      2'b01:   ref_pend_d = ref_pend_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      owner_q      <= OWN_CPU;
      own_we_q     <= 1'b0;
      rr_last_q    <= CL_CPU;
      ref_cnt_q    <= '0;
      ref_pend_q   <= '0;
      mc_read_q    <= 1'b0;
      mc_write_q   <= 1'b0;
      mc_refresh_q <= 1'b0;
      mc_addr_q    <= '0;
      mc_din_q     <= '0;
      mc_wdm_q     <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_dout_q   <= '0;
      vid_ack_q    <= 1'b0;
      vid_dout_q   <= '0;
`ifdef ARB_WDOG_EN
      wdog_cnt_q   <= '0;
      arb_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      own_we_q     <= own_we_d;
      rr_last_q    <= rr_last_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      mc_read_q    <= mc_read_d;
      mc_write_q   <= mc_write_d;
      mc_refresh_q <= mc_refresh_d;
      mc_addr_q    <= mc_addr_d;
      mc_din_q     <= mc_din_d;
      mc_wdm_q     <= mc_wdm_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_dout_q   <= cpu_dout_d;
      vid_ack_q    <= vid_ack_d;
      vid_dout_q   <= vid_dout_d;
`ifdef ARB_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      arb_err_q    <= arb_err_d;
`endif
    end
  end

  assign bus.mc_read    = mc_read_q;
  assign bus.mc_write   = mc_write_q;
  assign bus.mc_refresh = mc_refresh_q;
  assign bus.mc_addr    = mc_addr_q;
  assign bus.mc_din     = mc_din_q;
  assign bus.mc_wdm     = mc_wdm_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.vid_dout   = vid_dout_q;

`ifdef ARB_WDOG_EN
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter: a small controller model (busy for
//   4 cycles after each command pulse, read data derived from the address)
//   plus a negedge monitor that logs every command pulse in grant order.
//   Grant codes in the log: 0 = CPU, 1 = video, 2 = refresh.
module tb_sdram_port_arbiter;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic arb_err;
  int   tests  = 0;
  int   fails  = 0;

  sdram_port_arbiter_if bus();

  sdram_port_arbiter #(
    .FREQ        (54_000_000),
    .REFRESH_NS  (7800),
    .WDOG_CYCLES (16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  // Controller model
  logic init_busy = 1'b1;
  logic stuck     = 1'b0;
  int   bcnt;

  function automatic logic [15:0] model_data(input logic [21:0] a);
    if (a == 22'h000123) return 16'hBEEF;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt        <= 0;
      bus.mc_dout <= '0;
    end else if (bus.mc_read || bus.mc_write || bus.mc_refresh) begin
      bcnt <= 4;
      if (bus.mc_read) bus.mc_dout <= model_data(bus.mc_addr);
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  assign bus.mc_busy = init_busy | stuck | (bcnt != 0);

  // Monitor
  int   grants[$];
  int   n_pulse, n_ref, n_cack, n_vack, multi_err, adj_err, ack_err;
  logic prev_pulse, prev_cack, prev_vack;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_pulse = 1'b0;
      prev_cack  = 1'b0;
      prev_vack  = 1'b0;
    end else begin
      if ((int'(bus.mc_read) + int'(bus.mc_write) + int'(bus.mc_refresh)) > 1) multi_err++;
      if ((bus.mc_read || bus.mc_write || bus.mc_refresh) && prev_pulse) adj_err++;
      if (bus.mc_read || bus.mc_write || bus.mc_refresh) n_pulse++;
      if (bus.mc_refresh) begin
        grants.push_back(2);
        n_ref++;
      end else if (bus.mc_read || bus.mc_write) begin
        grants.push_back(bus.mc_addr[21] ? 1 : 0);
      end
      if (bus.cpu_ack) n_cack++;
      if (bus.vid_ack) n_vack++;
      if ((bus.cpu_ack && prev_cack) || (bus.vid_ack && prev_vack)) ack_err++;
      prev_pulse = bus.mc_read || bus.mc_write || bus.mc_refresh;
      prev_cack  = bus.cpu_ack;
      prev_vack  = bus.vid_ack;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    grants.delete();
    n_pulse = 0; n_ref = 0; n_cack = 0; n_vack = 0;
    multi_err = 0; adj_err = 0; ack_err = 0;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    init_busy   = 1'b1;
    stuck       = 1'b0;
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    bus.cpu_we  = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (5) tick();
    init_busy = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic test_reset();
    int k;
    resetn      = 1'b0;
    init_busy   = 1'b1;
    bus.cpu_req = 1'b1;
    bus.vid_req = 1'b1;
    bus.cpu_we  = 1'b0;
    bus.cpu_addr = 22'h000011;
    bus.vid_addr = 22'h200022;
    repeat (3) tick();
    tests++;
    if ({bus.mc_read, bus.mc_write, bus.mc_refresh, bus.cpu_ack, bus.vid_ack, arb_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b expected 000000",
               {bus.mc_read, bus.mc_write, bus.mc_refresh, bus.cpu_ack, bus.vid_ack, arb_err});
    end
    tests++;
    if ({bus.mc_addr, bus.mc_din, bus.mc_wdm, bus.cpu_dout, bus.vid_dout} !== 72'h0) begin
      fails++;
      $display("FAIL reset_buses: got %h expected 0",
               {bus.mc_addr, bus.mc_din, bus.mc_wdm, bus.cpu_dout, bus.vid_dout});
    end
    resetn = 1'b1;
    clear_mon();
    repeat (100) tick();
    tests++;
    if (n_pulse !== 0) begin
      fails++;
      $display("FAIL init_no_pulse: got %0d pulses expected 0", n_pulse);
    end
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    init_busy   = 1'b0;
    k = -1;
    for (int i = 1; i <= 500; i++) begin
      tick();
      if (bus.mc_refresh) begin
        k = i;
        break;
      end
    end
    tests++;
    if (k !== 423) begin
      fails++;
      $display("FAIL first_refresh_cycle: got %0d expected 423", k);
    end
    tests++;
    if (n_pulse !== 1) begin
      fails++;
      $display("FAIL first_refresh_only: got %0d pulses expected 1", n_pulse);
    end
  endtask

  task automatic test_cpu_read();
    int k;
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000123;
    bus.cpu_req  = 1'b1;
    tick();
    tests++;
    if ({bus.mc_read, bus.mc_write, bus.mc_refresh, bus.mc_addr} !== {3'b100, 22'h000123}) begin
      fails++;
      $display("FAIL rd_cmd: got %b/%h expected 100/000123",
               {bus.mc_read, bus.mc_write, bus.mc_refresh}, bus.mc_addr);
    end
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        tests++;
        if (bus.mc_read !== 1'b0) begin
          fails++;
          $display("FAIL rd_pulse_width: got %b expected 0", bus.mc_read);
        end
      end
      if (bus.cpu_ack) begin
        k = i;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    tests++;
    if (k !== 6) begin
      fails++;
      $display("FAIL rd_ack_latency: got %0d expected 6", k);
    end
    tests++;
    if (bus.cpu_dout !== 16'hBEEF) begin
      fails++;
      $display("FAIL rd_data: got %h expected BEEF", bus.cpu_dout);
    end
    tick();
    tests++;
    if (bus.cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL rd_ack_width: got %b expected 0", bus.cpu_ack);
    end
    repeat (10) tick();
    tests++;
    if ({n_pulse, n_cack} !== {32'd1, 32'd1}) begin
      fails++;
      $display("FAIL rd_counts: got pulses %0d acks %0d expected 1 1", n_pulse, n_cack);
    end
  endtask

  task automatic test_vid_read();
    int k;
    do_reset();
    bus.vid_addr = 22'h200040;
    bus.vid_req  = 1'b1;
    k = -1;
    for (int i = 0; i <= 40; i++) begin
      tick();
      if (bus.vid_ack) begin
        k = i;
        break;
      end
    end
    bus.vid_req = 1'b0;
    tests++;
    if (k !== 6) begin
      fails++;
      $display("FAIL vid_ack_latency: got %0d expected 6", k);
    end
    tests++;
    if ({bus.vid_dout, bus.cpu_dout} !== {16'hA5E5, 16'h0000}) begin
      fails++;
      $display("FAIL vid_data: got %h/%h expected A5E5/0000", bus.vid_dout, bus.cpu_dout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000010;
    bus.vid_addr = 22'h200020;
    bus.cpu_req  = 1'b1;
    bus.vid_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (grants.size() >= 6) break;
    end
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    repeat (20) tick();
    tests++;
    if (grants.size() !== 6) begin
      fails++;
      $display("FAIL rr_grant_count: got %0d expected 6", grants.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) begin
        tests++;
        if (grants[i] !== ((i % 2 == 0) ? 1 : 0)) begin
          fails++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grants[i], (i % 2 == 0) ? 1 : 0);
        end
      end
    end
    tests++;
    if ({n_cack, n_vack, ack_err, multi_err, adj_err} !== {32'd3, 32'd3, 32'd0, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL rr_acks: got cack %0d vack %0d ackerr %0d multi %0d adj %0d expected 3 3 0 0 0",
               n_cack, n_vack, ack_err, multi_err, adj_err);
    end
  endtask

  task automatic test_write();
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000123;
    bus.cpu_req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 22'h00ABCD;
    bus.cpu_din  = 16'h5A5A;
    bus.cpu_wdm  = 2'b01;
    bus.cpu_req  = 1'b1;
    tick();
    tests++;
    if ({bus.mc_read, bus.mc_write, bus.mc_addr, bus.mc_din, bus.mc_wdm} !==
        {2'b01, 22'h00ABCD, 16'h5A5A, 2'b01}) begin
      fails++;
      $display("FAIL wr_cmd: got rd%b wr%b a%h d%h m%b expected rd0 wr1 a00abcd d5a5a m01",
               bus.mc_read, bus.mc_write, bus.mc_addr, bus.mc_din, bus.mc_wdm);
    end
    tick();
    tests++;
    if ({bus.mc_write, bus.mc_din} !== {1'b0, 16'h5A5A}) begin
      fails++;
      $display("FAIL wr_hold: got wr%b d%h expected wr0 d5a5a", bus.mc_write, bus.mc_din);
    end
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_ack) break;
      tick();
    end
    bus.cpu_req = 1'b0;
    tests++;
    if ({bus.cpu_ack, bus.cpu_dout} !== {1'b1, 16'hBEEF}) begin
      fails++;
      $display("FAIL wr_ack_dout: got ack%b dout %h expected ack1 dout BEEF", bus.cpu_ack, bus.cpu_dout);
    end
    bus.vid_addr = 22'h200001;
    bus.vid_req  = 1'b1;
    tick();
    tick();
    bus.vid_req = 1'b0;
    tests++;
    if ({bus.mc_addr, bus.mc_din, bus.mc_wdm} !== {22'h200001, 16'h5A5A, 2'b01}) begin
      fails++;
      $display("FAIL rd_keeps_wdata: got a%h d%h m%b expected a200001 d5a5a m01",
               bus.mc_addr, bus.mc_din, bus.mc_wdm);
    end
    repeat (10) tick();
  endtask

`ifndef ARB_WDOG_EN
  task automatic test_refresh_sat();
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000010;
    bus.vid_addr = 22'h200020;
    stuck        = 1'b1;
    bus.cpu_req  = 1'b1;
    tick();
    repeat (1400) tick();
    tests++;
    if (grants.size() !== 1) begin
      fails++;
      $display("FAIL sat_stall: got %0d grants expected 1", grants.size());
    end
    clear_mon();
    bus.vid_req = 1'b1;
    stuck       = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
      if (bus.vid_ack) bus.vid_req = 1'b0;
    end
    tests++;
    if (grants.size() !== 4) begin
      fails++;
      $display("FAIL sat_grant_count: got %0d expected 4", grants.size());
    end
    if (grants.size() >= 3) begin
      tests++;
      if ({grants[0], grants[1], grants[2]} !== {32'd2, 32'd2, 32'd1}) begin
        fails++;
        $display("FAIL sat_order: got %0d %0d %0d expected 2 2 1", grants[0], grants[1], grants[2]);
      end
    end
    tests++;
    if ({n_ref, n_cack, n_vack} !== {32'd3, 32'd1, 32'd1}) begin
      fails++;
      $display("FAIL sat_counts: got ref %0d cack %0d vack %0d expected 3 1 1", n_ref, n_cack, n_vack);
    end
    tests++;
    if (arb_err !== 1'b0) begin
      fails++;
      $display("FAIL no_wdog_err: got %b expected 0", arb_err);
    end
  endtask
`else
  task automatic test_wdog();
    int k;
    do_reset();
    stuck        = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000055;
    bus.cpu_req  = 1'b1;
    tick();
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.cpu_ack) begin
        k = i;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    tests++;
    if (k !== 17) begin
      fails++;
      $display("FAIL wdog_latency: got %0d expected 17", k);
    end
    tests++;
    if ({arb_err, bus.cpu_dout} !== {1'b1, 16'hDEAD}) begin
      fails++;
      $display("FAIL wdog_err_data: got err%b dout %h expected err1 dout DEAD", arb_err, bus.cpu_dout);
    end
    stuck = 1'b0;
    repeat (10) tick();
    tests++;
    if (arb_err !== 1'b1) begin
      fails++;
      $display("FAIL wdog_sticky: got %b expected 1", arb_err);
    end
    do_reset();
    tests++;
    if (arb_err !== 1'b0) begin
      fails++;
      $display("FAIL wdog_reset_clear: got %b expected 0", arb_err);
    end
  endtask
`endif

  task automatic test_reset_midop();
    do_reset();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 22'h000077;
    bus.cpu_req  = 1'b1;
    repeat (3) tick();
    resetn    = 1'b0;
    init_busy = 1'b1;
    #1;
    tests++;
    if ({bus.mc_read, bus.cpu_ack, bus.mc_addr, bus.cpu_dout} !== 40'h0) begin
      fails++;
      $display("FAIL midop_async_clear: got rd%b ack%b a%h d%h expected all 0",
               bus.mc_read, bus.cpu_ack, bus.mc_addr, bus.cpu_dout);
    end
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    clear_mon();
    repeat (3) tick();
    init_busy = 1'b0;
    repeat (20) tick();
    tests++;
    if ({n_cack, n_pulse} !== {32'd0, 32'd0}) begin
      fails++;
      $display("FAIL midop_ack_lost: got acks %0d pulses %0d expected 0 0", n_cack, n_pulse);
    end
  endtask

  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.cpu_wdm  = '0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    clear_mon();
    test_reset();
    test_cpu_read();
    test_vid_read();
    test_back_to_back();
    test_write();
`ifndef ARB_WDOG_EN
    test_refresh_sat();
`else
    test_wdog();
`endif
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
